// File: rtl/alu_mc_param.sv
// Multi-cycle ALU with valid/ready handshakes and a 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_mc_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       S,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic             OF,
   output logic             Z,
   output logic             busy
);
   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_XOR = 3'b011,
      OP_SUB = 3'b100,
      OP_SRA = 3'b101,
      OP_SLL = 3'b110,
      OP_NOR = 3'b111
   } op_t;

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic [0:0] {IDLE, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   op_t              op;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_of;

   state_t           state, state_n;
   logic [WIDTH-1:0] r_q, r_n;
   logic             of_q, of_n;
   logic             z_q, z_n;

`ifndef ALU_FAST_SHIFT_EN
   localparam logic [SHW-1:0] ONE = SHW'(1);

   logic [WIDTH-1:0] sh_q, sh_n;
   logic [WIDTH-1:0] sh_src;
   logic [WIDTH-1:0] sh_step;
   logic             sh_left;
   logic [SHW-1:0]   cnt_q, cnt_n;
   logic             left_q, left_n;
`endif

   assign op   = op_t'(S);
   assign amt  = B[SHW-1:0];
   assign sum  = A + B;
   assign diff = A - B;

   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      case (op)
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_NOR: alu_res = ~(A | B);
         OP_ADD: begin
            alu_res = sum;
            alu_of  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_of  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
`ifdef ALU_FAST_SHIFT_EN
         OP_SRA: alu_res = $unsigned($signed(A) >>> amt);
         OP_SLL: alu_res = A << amt;
`else
         // Only reached with a zero amount; non-zero amounts go through the iterative path.
         OP_SRA: alu_res = A;
         OP_SLL: alu_res = A;
`endif
         default: alu_res = '0;
      endcase
   end

`ifndef ALU_FAST_SHIFT_EN
   // The first step shifts A on the accept edge; later steps shift the held partial result.
   always_comb begin
      sh_src  = (state == IDLE) ? A : sh_q;
      sh_left = (state == IDLE) ? (op == OP_SLL) : left_q;
      sh_step = sh_left ? {sh_src[WIDTH-2:0], 1'b0} : {sh_src[WIDTH-1], sh_src[WIDTH-1:1]};
   end
`endif

   always_comb begin
      state_n = state;
      r_n     = r_q;
      of_n    = of_q;
      z_n     = z_q;
`ifndef ALU_FAST_SHIFT_EN
      sh_n    = sh_q;
      cnt_n   = cnt_q;
      left_n  = left_q;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
               state_n = DONE;
               r_n     = alu_res;
               of_n    = alu_of;
               z_n     = (alu_res == '0);
`else
               if ((op == OP_SRA || op == OP_SLL) && amt != '0) begin
                  sh_n   = sh_step;
                  cnt_n  = amt - ONE;
                  left_n = (op == OP_SLL);
                  if (amt == ONE) begin
                     state_n = DONE;
                     r_n     = sh_step;
                     of_n    = 1'b0;
                     z_n     = (sh_step == '0);
                  end else begin
                     state_n = SHIFT;
                  end
               end else begin
                  state_n = DONE;
                  r_n     = alu_res;
                  of_n    = alu_of;
                  z_n     = (alu_res == '0);
               end
`endif
            end
         end
`ifndef ALU_FAST_SHIFT_EN
         SHIFT: begin
            sh_n  = sh_step;
            cnt_n = cnt_q - ONE;
            if (cnt_q == ONE) begin
               state_n = DONE;
               r_n     = sh_step;
               of_n    = 1'b0;
               z_n     = (sh_step == '0);
            end
         end
`endif
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         r_q    <= '0;
         of_q   <= 1'b0;
         z_q    <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
         sh_q   <= '0;
         cnt_q  <= '0;
         left_q <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         r_q    <= r_n;
         of_q   <= of_n;
         z_q    <= z_n;
`ifndef ALU_FAST_SHIFT_EN
         sh_q   <= sh_n;
         cnt_q  <= cnt_n;
         left_q <= left_n;
`endif
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign R         = r_q;
   assign OF        = of_q;
   assign Z         = z_q;

endmodule
